block_rmw_scheduler: RTL and testbench

- Sequences read-modify-write transactions on port A of the interleaved 2x2 block framebuffer memory.
- Arbitrates port A between two requesters: rasterizer (req 0) and clear/fill engine (req 1).
- For each granted transaction: issues the read, signals when q data is valid, waits for the requester's modified data, then issues the write.
- The 256-bit colour buses bypass this block; it drives only the address, clock enable, write enable and grant/handshake signals.

---
 rtl/gpu_mem_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 33 +++
 rtl/block_rmw_scheduler.sv | 135 +++++++++++++
 tb/tb_block_rmw_scheduler.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the block framebuffer memory path: address layout,
// default legal block range and the RMW scheduler state encoding.
package gpu_mem_pkg;

    localparam int BA_W      = 13;
    localparam int X_MSB     = 12;
    localparam int X_LSB     = 6;
    localparam int Y_MSB     = 5;
    localparam int Y_LSB     = 0;
    localparam int X_MAX_DEF = 70;
    localparam int Y_MAX_DEF = 52;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_MODIFY = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // A block address is legal when both fields lie inside the framebuffer.
    function automatic logic addr_legal(input logic [BA_W-1:0] a,
                                        input int x_max, input int y_max);
        return (int'(a[X_MSB:X_LSB]) <= x_max) && (int'(a[Y_MSB:Y_LSB]) <= y_max);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the requester not granted last
// wins; the pointer only moves when the owner accepts the grant (en_i).
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // Index of the requester granted last; reset value 1 lets req 0 win first.
    logic last_q, last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (en_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/block_rmw_scheduler.sv
// Read-modify-write sequencer for port A of the 2x2 block framebuffer memory,
// shared between the rasterizer (req 0) and the clear/fill engine (req 1).
module block_rmw_scheduler
    import gpu_mem_pkg::*;
#(
    parameter int RD_LAT      = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int X_MAX       = X_MAX_DEF,
    parameter int Y_MAX       = Y_MAX_DEF
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [1:0]      req_i,
    input  logic [BA_W-1:0] addr0_i,
    input  logic [BA_W-1:0] addr1_i,
    input  logic [1:0]      wb_valid_i,
    output logic [1:0]      gnt_o,
    output logic            rd_valid_o,
    output logic [1:0]      done_o,
    output logic            err_o,
    output logic            busy_o,
    output logic [BA_W-1:0] mem_block_address_a,
    output logic            mem_clk_en_a,
    output logic            mem_wren
);

    state_e          state_q, state_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [BA_W-1:0] addr_q, addr_d;
    logic            err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [1:0]      arb_gnt;
    logic            arb_en;
    logic [BA_W-1:0] sel_addr;
    logic            wb_ok;

    assign arb_en   = (state_q == ST_IDLE) && (req_i != 2'b00);
    assign sel_addr = arb_gnt[1] ? addr1_i : addr0_i;
    assign wb_ok    = (wb_valid_i & gnt_q) != 2'b00;

    rr_arbiter2 u_arb (
        .clk_i (clk),
        .rst_i (clr),
        .req_i (req_i),
        .en_i  (arb_en),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i != 2'b00) begin
                    gnt_d  = arb_gnt;
                    addr_d = sel_addr;
                    cnt_d  = 8'd0;
                    if (addr_legal(sel_addr, X_MAX, Y_MAX)) begin
                        state_d = ST_READ;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (cnt_q == 8'(RD_LAT - 1)) begin
                    state_d = ST_MODIFY;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_MODIFY: begin
                // Write-back wins over a timeout landing in the same cycle.
                if (wb_ok) begin
                    state_d = ST_WRITE;
                end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WRITE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
                addr_d  = '0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
                addr_d  = '0;
                err_d   = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            addr_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign gnt_o               = gnt_q;
    assign rd_valid_o          = (state_q == ST_MODIFY);
    assign done_o              = (state_q == ST_DONE) ? gnt_q : 2'b00;
    assign err_o               = (state_q == ST_DONE) && err_q;
    assign busy_o              = (state_q != ST_IDLE);
    assign mem_block_address_a = addr_q;
    assign mem_clk_en_a        = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign mem_wren            = (state_q == ST_WRITE);

endmodule

// File: tb/tb_block_rmw_scheduler.sv
// Self-checking bench for block_rmw_scheduler (RD_LAT=2, TIMEOUT_CYC=4).
module tb_block_rmw_scheduler;

    logic        clk = 1'b0;
    logic        clr;
    logic [1:0]  req_i;
    logic [12:0] addr0_i;
    logic [12:0] addr1_i;
    logic [1:0]  wb_valid_i;
    logic [1:0]  gnt_o;
    logic        rd_valid_o;
    logic [1:0]  done_o;
    logic        err_o;
    logic        busy_o;
    logic [12:0] mem_block_address_a;
    logic        mem_clk_en_a;
    logic        mem_wren;

    block_rmw_scheduler #(
        .RD_LAT      (2),
        .TIMEOUT_CYC (4),
        .X_MAX       (70),
        .Y_MAX       (52)
    ) dut (
        .clk                 (clk),
        .clr                 (clr),
        .req_i               (req_i),
        .addr0_i             (addr0_i),
        .addr1_i             (addr1_i),
        .wb_valid_i          (wb_valid_i),
        .gnt_o               (gnt_o),
        .rd_valid_o          (rd_valid_o),
        .done_o              (done_o),
        .err_o               (err_o),
        .busy_o              (busy_o),
        .mem_block_address_a (mem_block_address_a),
        .mem_clk_en_a        (mem_clk_en_a),
        .mem_wren            (mem_wren)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wr_seen = 0;

    always @(posedge clk) cyc++;

    // scoreboard: {done_o, err_o} per completion, and write addresses
    logic [2:0]  exp_q[$];
    logic [12:0] wr_q[$];
    logic [2:0]  mon_done_e;
    logic [12:0] mon_wr_e;

    always @(negedge clk) begin
        if (clr === 1'b0) begin
            if (mem_wren === 1'b1) begin
                wr_seen++;
                n_tests++;
                if (wr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_write: unexpected write addr=%h, none expected", mem_block_address_a);
                end else begin
                    mon_wr_e = wr_q.pop_front();
                    if (mem_block_address_a !== mon_wr_e || mem_clk_en_a !== 1'b1) begin
                        n_fail++;
                        $display("FAIL sb_write: addr=%h clk_en=%b, expected addr=%h clk_en=1",
                                 mem_block_address_a, mem_clk_en_a, mon_wr_e);
                    end
                end
            end
            if (done_o !== 2'b00) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_done: unexpected done=%b err=%b", done_o, err_o);
                end else begin
                    mon_done_e = exp_q.pop_front();
                    if ({done_o, err_o} !== mon_done_e) begin
                        n_fail++;
                        $display("FAIL sb_done: got done/err=%b, expected %b", {done_o, err_o}, mon_done_e);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        clr        = 1'b1;
        req_i      = 2'b00;
        wb_valid_i = 2'b00;
        exp_q.delete();
        wr_q.delete();
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_txn(input int id, input logic [12:0] a, input bit legal, input string name);
        logic [1:0] bitv;
        bit         found;
        bitv = (id == 0) ? 2'b01 : 2'b10;
        if (id == 0) addr0_i = a; else addr1_i = a;
        exp_q.push_back({bitv, ~legal});
        if (legal) wr_q.push_back(a);
        req_i = bitv;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_o) req_i = 2'b00;
            if (done_o !== 2'b00) begin
                found = 1'b1;
                break;
            end
            wb_valid_i = rd_valid_o ? bitv : 2'b00;
        end
        wb_valid_i = 2'b00;
        n_tests++;
        if (!found || {done_o, err_o} !== {bitv, ~legal}) begin
            n_fail++;
            $display("FAIL %s: found=%0d done/err=%b, expected %b", name, found, {done_o, err_o}, {bitv, ~legal});
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr        = 1'b1;
        req_i      = 2'b00;
        wb_valid_i = 2'b00;
        addr0_i    = 13'h0;
        addr1_i    = 13'h0;
        @(negedge clk);
        n_tests++;
        if ({gnt_o, done_o, err_o, rd_valid_o, busy_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 0", {gnt_o, done_o, err_o, rd_valid_o, busy_o});
        end
        n_tests++;
        if ({mem_block_address_a, mem_clk_en_a, mem_wren} !== 15'b0) begin
            n_fail++;
            $display("FAIL reset_mem: got %h, expected 0", {mem_block_address_a, mem_clk_en_a, mem_wren});
        end
        clr = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy_o !== 1'b0 || gnt_o !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b gnt=%b, expected 0/00", busy_o, gnt_o);
        end
    endtask

    task automatic test_basic();
        addr0_i = 13'h0041;
        exp_q.push_back(3'b010);
        wr_q.push_back(13'h0041);
        req_i = 2'b01;
        @(negedge clk); // t1
        n_tests++;
        if (gnt_o !== 2'b01 || mem_clk_en_a !== 1'b1 || mem_wren !== 1'b0 || rd_valid_o !== 1'b0
            || mem_block_address_a !== 13'h0041) begin
            n_fail++;
            $display("FAIL basic_t1: gnt=%b ce=%b we=%b rv=%b a=%h, expected 01 1 0 0 0041",
                     gnt_o, mem_clk_en_a, mem_wren, rd_valid_o, mem_block_address_a);
        end
        req_i = 2'b00;
        @(negedge clk); // t2
        n_tests++;
        if (mem_clk_en_a !== 1'b1 || rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_t2: ce=%b rv=%b, expected 1 0", mem_clk_en_a, rd_valid_o);
        end
        @(negedge clk); // t3
        n_tests++;
        if (rd_valid_o !== 1'b1 || mem_clk_en_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_t3: rv=%b ce=%b, expected 1 0", rd_valid_o, mem_clk_en_a);
        end
        wb_valid_i = 2'b01;
        @(negedge clk); // t4
        n_tests++;
        if (mem_wren !== 1'b1 || mem_block_address_a !== 13'h0041 || rd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_t4: we=%b a=%h rv=%b, expected 1 0041 0", mem_wren, mem_block_address_a, rd_valid_o);
        end
        wb_valid_i = 2'b00;
        @(negedge clk); // t5
        n_tests++;
        if (done_o !== 2'b01 || err_o !== 1'b0 || gnt_o !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_t5: done=%b err=%b gnt=%b, expected 01 0 01", done_o, err_o, gnt_o);
        end
        @(negedge clk); // t6
        n_tests++;
        if (busy_o !== 1'b0 || gnt_o !== 2'b00 || mem_block_address_a !== 13'h0) begin
            n_fail++;
            $display("FAIL basic_t6: busy=%b gnt=%b a=%h, expected 0 00 0000", busy_o, gnt_o, mem_block_address_a);
        end
    endtask

    task automatic test_back_to_back();
        int  prev;
        int  w0;
        bit  found;
        logic [1:0] exp_g;
        do_reset();
        addr0_i = 13'h0102;
        addr1_i = 13'h0a33;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back((k % 2 == 0) ? 3'b010 : 3'b100);
            wr_q.push_back((k % 2 == 0) ? 13'h0102 : 13'h0a33);
        end
        w0         = wr_seen;
        prev       = 0;
        req_i      = 2'b11;
        wb_valid_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            found = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done_o !== 2'b00) begin
                    found = 1'b1;
                    break;
                end
            end
            n_tests++;
            if (!found || done_o !== exp_g) begin
                n_fail++;
                $display("FAIL b2b_grant%0d: found=%0d done=%b, expected %b", k, found, done_o, exp_g);
            end
            if (k > 0) begin
                n_tests++;
                if (cyc - prev != 6) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles, expected 6", k, cyc - prev);
                end
            end
            prev = cyc;
            if (k == 2) begin
                @(negedge clk);
                @(negedge clk);
                req_i = 2'b00;
            end
        end
        wb_valid_i = 2'b00;
        @(negedge clk);
        n_tests++;
        if (wr_seen - w0 != 4 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_writes: writes=%0d busy=%b, expected 4 0", wr_seen - w0, busy_o);
        end
    endtask

    task automatic test_illegal();
        int n;
        bit bad;
        bit found;
        addr1_i = {7'd71, 6'd0};
        exp_q.push_back(3'b101);
        req_i = 2'b10;
        n     = 0;
        bad   = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n++;
            if (busy_o) req_i = 2'b00;
            if (mem_clk_en_a || mem_wren) bad = 1'b1;
            if (done_o !== 2'b00) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found || n > 2 || done_o !== 2'b10 || err_o !== 1'b1 || bad) begin
            n_fail++;
            $display("FAIL illegal_x: found=%0d cyc=%0d done=%b err=%b memacc=%0d, expected 1 <=2 10 1 0",
                     found, n, done_o, err_o, bad);
        end
        @(negedge clk);
    endtask

    task automatic test_boundary();
        run_txn(0, 13'h0000, 1'b1, "bound_zero");
        run_txn(1, {7'd70, 6'd52}, 1'b1, "bound_max");
        run_txn(0, {7'd70, 6'd53}, 1'b0, "bound_y_over");
    endtask

    task automatic test_timeout();
        int rdv;
        bit we;
        bit found;
        addr0_i = 13'h0203;
        exp_q.push_back(3'b011);
        req_i = 2'b01;
        rdv   = 0;
        we    = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_o) req_i = 2'b00;
            if (rd_valid_o) rdv++;
            if (mem_wren) we = 1'b1;
            if (done_o !== 2'b00) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!found || rdv != 4 || we || err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout: found=%0d rd_valid_cycles=%0d wren=%0d err=%b, expected 1 4 0 1",
                     found, rdv, we, err_o);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_wb();
        bit found;
        addr0_i = 13'h0305;
        exp_q.push_back(3'b010);
        wr_q.push_back(13'h0305);
        req_i = 2'b01;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy_o) req_i = 2'b00;
            if (rd_valid_o) begin
                found = 1'b1;
                break;
            end
        end
        wb_valid_i = 2'b10;
        @(negedge clk);
        n_tests++;
        if (!found || rd_valid_o !== 1'b1 || mem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_wb: found=%0d rv=%b we=%b, expected 1 1 0", found, rd_valid_o, mem_wren);
        end
        wb_valid_i = 2'b01;
        @(negedge clk);
        n_tests++;
        if (mem_wren !== 1'b1 || mem_block_address_a !== 13'h0305) begin
            n_fail++;
            $display("FAIL ignore_wb_write: we=%b a=%h, expected 1 0305", mem_wren, mem_block_address_a);
        end
        wb_valid_i = 2'b00;
        @(negedge clk);
        n_tests++;
        if (done_o !== 2'b01 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_wb_done: done=%b err=%b, expected 01 0", done_o, err_o);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit found;
        addr0_i = 13'h0407;
        exp_q.push_back(3'b010);
        wr_q.push_back(13'h0407);
        req_i = 2'b01;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy_o) req_i = 2'b00;
            if (rd_valid_o) wb_valid_i = 2'b01;
            if (mem_wren === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        #2;
        clr        = 1'b1;
        wb_valid_i = 2'b00;
        #1;
        n_tests++;
        if (!found || mem_wren !== 1'b0 || mem_clk_en_a !== 1'b0
            || {gnt_o, done_o, err_o, rd_valid_o, busy_o, mem_block_address_a} !== 20'b0) begin
            n_fail++;
            $display("FAIL reset_mid: found=%0d we=%b ce=%b gnt=%b busy=%b a=%h, expected all 0",
                     found, mem_wren, mem_clk_en_a, gnt_o, busy_o, mem_block_address_a);
        end
        exp_q.delete();
        @(negedge clk);
        clr     = 1'b0;
        addr0_i = 13'h0509;
        addr1_i = 13'h060a;
        exp_q.push_back(3'b010);
        wr_q.push_back(13'h0509);
        req_i = 2'b11;
        @(negedge clk);
        n_tests++;
        if (gnt_o !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_mid_rr: gnt=%b, expected 01", gnt_o);
        end
        req_i = 2'b00;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_o !== 2'b00) begin
                found = 1'b1;
                break;
            end
            wb_valid_i = rd_valid_o ? 2'b01 : 2'b00;
        end
        wb_valid_i = 2'b00;
        n_tests++;
        if (!found || done_o !== 2'b01 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_done: found=%0d done=%b err=%b, expected 1 01 0", found, done_o, err_o);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_boundary();
        test_timeout();
        test_ignore_wb();
        test_reset_mid();
        repeat (2) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: pending done=%0d writes=%0d, expected 0 0", exp_q.size(), wr_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
